i2c_slave_sequencer: RTL and testbench
======================================

Name: i2c_slave_sequencer

Overview:
- Synchronous I2C slave controller, clocked by the system clock; it oversamples SCL/SDA instead of clocking on SCL edges.
- Detects START/STOP, sequences the 5-bit slave state, and shifts device address, register pointer and data bytes.
- Drives the SDA open-drain enable path and presents a single-port register-file interface (write strobe, read strobe) to the PID register bank.
- Exports `state` in the team's established encoding so downstream logic and debug taps stay consistent.

Parameters:
- DEV_ADDR, 7'h4A, 7-bit slave address this block ACKs.
- RESET_PTR, 8'h00, register pointer value after reset.

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  block enable; 0 forces IDLE and releases SDA.
- scl_in  input  1  SCL pad input (asynchronous).
- sda_in  input  1  SDA pad input (asynchronous).
- sda_out  output  1  SDA drive value (always 0 when driven).
- sda_ena  output  1  SDA output enable; 1 = pull low / drive.
- state  output  5  current sequencer state.
- reg_addr  output  8  register pointer to the register bank.
- wr_data  output  8  received data byte.
- wr_en  output  1  one-clk write strobe.
- rd_data  input  8  register bank read data; combinational from reg_addr.
- rd_en  output  1  one-clk strobe, asserted in the cycle rd_data is captured.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE(0), reg_addr=RESET_PTR, sda_out=0, sda_ena=0, wr_en=0, rd_en=0, wr_data=0, busy=0. Synchronizer flops reset to 1.
- Input sync: scl_in and sda_in each pass through 2-flop synchronizers, then a third register for edge detection.
  - scl_rise / scl_fall are one-clk pulses.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - Pin-to-pulse latency is 3 clk. Registered outputs update 1 clk after the pulse.
- State encoding: IDLE=0, START=1, DEVICE_ADDR=2, READ_OR_WRITE=3, ADDR_ACK=4, REG_ADDR=5, REG_ACK=6, WRITE=7, WRITE_ACK=8, READ=9, READ_ACK=10, STOP=11.
- Priority: rst > ena=0 > START/STOP detect > scl edges.
  - START in any state, including mid-byte and repeated start: go to START, sda_ena=0, bit_cnt=0.
  - STOP in any non-IDLE state: go to STOP for 1 clk, then IDLE, sda_ena=0. STOP while in IDLE is ignored.
- Sampling rule: SDA is sampled on scl_rise and shifted MSB first; bit_cnt increments on each scl_rise. All state changes other than START/STOP happen on scl_fall.
- START, on scl_fall: go to DEVICE_ADDR.
- DEVICE_ADDR: after 7 bits, on scl_fall go to READ_OR_WRITE.
- READ_OR_WRITE: sample rw on scl_rise. On scl_fall:
  - address == DEV_ADDR: go to ADDR_ACK with sda_ena=1.
  - otherwise: go to IDLE and stay passive until the next START.
- ADDR_ACK, on scl_fall:
  - rw=0: go to REG_ADDR, sda_ena=0.
  - rw=1: pulse rd_en, load the shifter from rd_data, go to READ, sda_ena = ~bit7.
- REG_ADDR: after 8 bits, on scl_fall load reg_addr and go to REG_ACK with sda_ena=1.
- REG_ACK, on scl_fall: go to WRITE, sda_ena=0.
- WRITE: after 8 bits, on scl_fall:
  - update wr_data, pulse wr_en for 1 clk with the current reg_addr;
  - go to WRITE_ACK, sda_ena=1.
- WRITE_ACK, on scl_fall: reg_addr += 1 (255 wraps to 0), go to WRITE, sda_ena=0.
- READ: on each scl_fall, shift so sda_ena = ~next_bit (open drain: drive only zeros). After the 8th bit's scl_fall: go to READ_ACK, sda_ena=0.
- READ_ACK: sample the master's ACK on scl_rise. On scl_fall:
  - ACK=0: reg_addr += 1 (wraps), pulse rd_en, reload the shifter, go to READ, drive MSB.
  - NACK=1: go to IDLE, sda_ena=0.
- sda_out is held at 0 at all times. Only sda_ena toggles.
- ena=0: next clk state=IDLE, sda_ena=0; reg_addr is held.
- Reset mid-transfer: all outputs return to reset values on the next clk, and the in-flight byte is discarded.

Test Plan:
- Write: START, 0x4A+W, reg 0x10, data 0xA5, STOP -> ACK on all 3 bytes; wr_en pulses exactly once with reg_addr=0x10, wr_data=0xA5; state ends at IDLE.
- Burst read: preload bank[0x20]=0x3C, bank[0x21]=0xC3; write reg 0x20, repeated START, 0x4A+R; master ACKs byte 1, NACKs byte 2 -> SDA carries 0x3C then 0xC3; rd_en pulses twice; reg_addr=0x21.
- Address mismatch: START, 0x4B+W, 0x55 -> sda_ena never asserted, wr_en never pulses, state=IDLE after the 8th bit.
- Pointer wrap: write reg 0xFF with data 0x11, 0x22 -> writes land at 0xFF and then 0x00.
- Abort: STOP after 4 bits of the data byte -> no wr_en, state goes STOP then IDLE, sda_ena=0. Repeat with rst asserted mid-ADDR_ACK -> sda_ena=0 and state=0 on the next clk.
- ena=0 during READ -> SDA released within 1 clk, state=IDLE, reg_addr unchanged.

Source files
------------

// File: rtl/i2c_slave_sequencer.sv
// I2C slave sequencer: oversamples SCL/SDA on clk, decodes START/STOP,
// walks the slave byte protocol and exposes a single-port register-bank
// interface (reg_addr, wr_data/wr_en, rd_data/rd_en).
//
// state           | meaning
// ----------------+--------------------------------------------------
// IDLE        (0) | bus passive, waiting for START
// START       (1) | START seen, waiting for first SCL fall
// DEVICE_ADDR (2) | shifting in 7 address bits
// READ_OR_WRITE(3)| sampling R/W bit, address compare on SCL fall
// ADDR_ACK    (4) | driving ACK for our address
// REG_ADDR    (5) | shifting in register pointer
// REG_ACK     (6) | driving ACK for pointer byte
// WRITE       (7) | shifting in data byte
// WRITE_ACK   (8) | driving ACK for data byte
// READ        (9) | shifting data byte out on SDA
// READ_ACK   (10) | sampling master ACK/NACK
// STOP       (11) | STOP seen, one clk before IDLE

`timescale 1ns/1ps

module i2c_slave_sequencer #(
    parameter logic [6:0] DEV_ADDR  = 7'h4A,
    parameter logic [7:0] RESET_PTR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_ena,
    output logic [4:0] state,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    input  logic [7:0] rd_data,
    output logic       rd_en,
    output logic       busy
);

    typedef enum logic [4:0] {
        S_IDLE          = 5'd0,
        S_START         = 5'd1,
        S_DEVICE_ADDR   = 5'd2,
        S_READ_OR_WRITE = 5'd3,
        S_ADDR_ACK      = 5'd4,
        S_REG_ADDR      = 5'd5,
        S_REG_ACK       = 5'd6,
        S_WRITE         = 5'd7,
        S_WRITE_ACK     = 5'd8,
        S_READ          = 5'd9,
        S_READ_ACK      = 5'd10,
        S_STOP          = 5'd11
    } state_t;

    state_t     st;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] sh;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       ack_n;

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det = ~sda_s2 &  sda_d & scl_s2;
    assign stop_det  =  sda_s2 & ~sda_d & scl_s2;

    // Protocol sequencer; all outputs registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            sda_ena  <= 1'b0;
            reg_addr <= RESET_PTR;
            wr_data  <= 8'h00;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            sh       <= 8'h00;
            bit_cnt  <= 4'd0;
            rw       <= 1'b0;
            ack_n    <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            if (!ena) begin
                st      <= S_IDLE;
                sda_ena <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                st      <= S_START;
                sda_ena <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (stop_det && st != S_IDLE) begin
                st      <= S_STOP;
                sda_ena <= 1'b0;
            end else if (st == S_STOP) begin
                st <= S_IDLE;
            end else if (scl_rise) begin
                case (st)
                    S_DEVICE_ADDR, S_REG_ADDR, S_WRITE: begin
                        sh      <= {sh[6:0], sda_s2};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    S_READ_OR_WRITE: begin
                        rw      <= sda_s2;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    S_READ: bit_cnt <= bit_cnt + 4'd1;
                    S_READ_ACK: begin
                        ack_n <= sda_s2;
                        // Advance the pointer already on the ACK rise so the
                        // combinational rd_data reflects the next register by
                        // the time it is captured on the following SCL fall.
                        if (!sda_s2)
                            reg_addr <= reg_addr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (st)
                    S_START: begin
                        st      <= S_DEVICE_ADDR;
                        bit_cnt <= 4'd0;
                    end
                    S_DEVICE_ADDR: begin
                        if (bit_cnt == 4'd7)
                            st <= S_READ_OR_WRITE;
                    end
                    S_READ_OR_WRITE: begin
                        if (sh[6:0] == DEV_ADDR) begin
                            st      <= S_ADDR_ACK;
                            sda_ena <= 1'b1;
                        end else begin
                            st <= S_IDLE;
                        end
                    end
                    S_ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        if (!rw) begin
                            st      <= S_REG_ADDR;
                            sda_ena <= 1'b0;
                        end else begin
                            rd_en   <= 1'b1;
                            sh      <= rd_data;
                            st      <= S_READ;
                            sda_ena <= ~rd_data[7];
                        end
                    end
                    S_REG_ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            reg_addr <= sh;
                            st       <= S_REG_ACK;
                            sda_ena  <= 1'b1;
                        end
                    end
                    S_REG_ACK: begin
                        st      <= S_WRITE;
                        sda_ena <= 1'b0;
                        bit_cnt <= 4'd0;
                    end
                    S_WRITE: begin
                        if (bit_cnt == 4'd8) begin
                            wr_data <= sh;
                            wr_en   <= 1'b1;
                            st      <= S_WRITE_ACK;
                            sda_ena <= 1'b1;
                        end
                    end
                    S_WRITE_ACK: begin
                        reg_addr <= reg_addr + 8'd1;
                        st       <= S_WRITE;
                        sda_ena  <= 1'b0;
                        bit_cnt  <= 4'd0;
                    end
                    S_READ: begin
                        if (bit_cnt == 4'd8) begin
                            st      <= S_READ_ACK;
                            sda_ena <= 1'b0;
                        end else begin
                            sh      <= {sh[6:0], 1'b0};
                            sda_ena <= ~sh[6];
                        end
                    end
                    S_READ_ACK: begin
                        bit_cnt <= 4'd0;
                        if (!ack_n) begin
                            rd_en   <= 1'b1;
                            sh      <= rd_data;
                            st      <= S_READ;
                            sda_ena <= ~rd_data[7];
                        end else begin
                            st      <= S_IDLE;
                            sda_ena <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Open drain: only the enable toggles, the driven value is always low
    assign sda_out = 1'b0;
    assign state   = st;
    assign busy    = (st != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_sequencer.sv
// Directed bench for i2c_slave_sequencer: an I2C master model bit-bangs
// SCL/SDA over an open-drain line, a register bank model feeds rd_data.
`timescale 1ns/1ps

module tb_i2c_slave_sequencer;

    localparam int Q = 5;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst, ena, scl_m, sda_m;
    logic       sda_out, sda_ena, wr_en, rd_en, busy;
    logic [4:0] state;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic [7:0] bank [0:255];

    wire sda_line = sda_ena ? (sda_m & sda_out) : sda_m;

    assign rd_data = bank[reg_addr];

    always #5 clk = ~clk;

    i2c_slave_sequencer #(.DEV_ADDR(7'h4A), .RESET_PTR(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .sda_ena  (sda_ena),
        .state    (state),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .busy     (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         ena_cnt = 0;
    logic [7:0] wr_addr_log [0:63];
    logic [7:0] wr_data_log [0:63];

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] = reg_addr;
                wr_data_log[wr_cnt] = wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (rd_en)
            rd_cnt = rd_cnt + 1;
        if (sda_ena)
            ena_cnt = ena_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        wclk(Q); sda_m = b;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); s = sda_line;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--)
            bit_cycle(d[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack, s);
    endtask

    // Works both from idle bus and as a repeated START with SCL low
    task automatic i2c_start();
        wclk(Q); sda_m = 1'b1;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); sda_m = 1'b1;
        wclk(2 * Q);
    endtask

    typedef struct {
        logic [6:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       match;
    } wvec_t;

    wvec_t vecs [4];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, s, found;
        logic [7:0] d, nxt;
        int         wb, rb, eb;

        vecs[0] = '{dev: 7'h4A, ptr: 8'h10, data: 8'hA5, match: 1'b1};
        vecs[1] = '{dev: 7'h4A, ptr: 8'h7E, data: 8'h5A, match: 1'b1};
        vecs[2] = '{dev: 7'h4B, ptr: 8'h55, data: 8'h00, match: 1'b0};
        vecs[3] = '{dev: 7'h25, ptr: 8'h94, data: 8'h00, match: 1'b0};

        for (int i = 0; i < 256; i++)
            bank[i] = 8'(i) ^ 8'h5A;
        bank[8'h20] = 8'h3C;
        bank[8'h21] = 8'hC3;

        rst = 1'b1; ena = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wclk(3);
        chk("rst_state",    32'(state),    0);
        chk("rst_reg_addr", 32'(reg_addr), 0);
        chk("rst_sda_ena",  32'(sda_ena),  0);
        chk("rst_sda_out",  32'(sda_out),  0);
        chk("rst_wr_en",    32'(wr_en),    0);
        chk("rst_rd_en",    32'(rd_en),    0);
        chk("rst_wr_data",  32'(wr_data),  0);
        chk("rst_busy",     32'(busy),     0);
        rst = 1'b0;
        wclk(5);

        // Table-driven write transactions (match and address mismatch)
        for (int v = 0; v < 4; v++) begin
            wb = wr_cnt; eb = ena_cnt;
            i2c_start();
            send_byte({vecs[v].dev, 1'b0}, ack);
            if (vecs[v].match) begin
                chk("w_addr_ack", 32'(ack), 0);
                send_byte(vecs[v].ptr, ack);
                chk("w_ptr_ack", 32'(ack), 0);
                send_byte(vecs[v].data, ack);
                chk("w_data_ack", 32'(ack), 0);
                i2c_stop();
                nxt = vecs[v].ptr + 8'd1;
                chk("w_wr_count", 32'(wr_cnt - wb), 1);
                chk("w_wr_addr",  32'(wr_addr_log[wb]), 32'(vecs[v].ptr));
                chk("w_wr_data",  32'(wr_data_log[wb]), 32'(vecs[v].data));
                chk("w_ptr_inc",  32'(reg_addr), 32'(nxt));
                chk("w_end_idle", 32'(state), 0);
            end else begin
                chk("m_addr_nack", 32'(ack), 1);
                chk("m_idle_after_addr", 32'(state), 0);
                send_byte(vecs[v].ptr, ack);
                chk("m_ptr_nack", 32'(ack), 1);
                i2c_stop();
                chk("m_no_drive", 32'(ena_cnt - eb), 0);
                chk("m_no_write", 32'(wr_cnt - wb), 0);
                chk("m_idle", 32'(state), 0);
            end
        end

        // Burst read with repeated START: ACK first byte, NACK second
        rb = rd_cnt;
        i2c_start();
        send_byte(8'h94, ack);  chk("r_addr_w_ack", 32'(ack), 0);
        send_byte(8'h20, ack);  chk("r_ptr_ack", 32'(ack), 0);
        i2c_start();
        send_byte(8'h95, ack);  chk("r_addr_r_ack", 32'(ack), 0);
        read_byte(1'b0, d);     chk("r_byte0", 32'(d), 32'h3C);
        read_byte(1'b1, d);     chk("r_byte1", 32'(d), 32'hC3);
        i2c_stop();
        chk("r_rd_count", 32'(rd_cnt - rb), 2);
        chk("r_reg_addr", 32'(reg_addr), 32'h21);
        chk("r_end_idle", 32'(state), 0);

        // Pointer wrap across 0xFF
        wb = wr_cnt;
        i2c_start();
        send_byte(8'h94, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);  chk("wrap_d0_ack", 32'(ack), 0);
        send_byte(8'h22, ack);  chk("wrap_d1_ack", 32'(ack), 0);
        i2c_stop();
        chk("wrap_count", 32'(wr_cnt - wb), 2);
        chk("wrap_addr0", 32'(wr_addr_log[wb]), 32'hFF);
        chk("wrap_data0", 32'(wr_data_log[wb]), 32'h11);
        chk("wrap_addr1", 32'(wr_addr_log[wb + 1]), 32'h00);
        chk("wrap_data1", 32'(wr_data_log[wb + 1]), 32'h22);

        // STOP after 4 data bits
        wb = wr_cnt;
        i2c_start();
        send_byte(8'h94, ack);
        send_byte(8'h40, ack);
        bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b1, s);
        chk("abort_mid_write", 32'(state), 7);
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); sda_m = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            wclk(1);
            if (state == 5'd11) found = 1'b1;
        end
        chk("abort_stop_seen", 32'(found), 1);
        wclk(1);
        chk("abort_idle", 32'(state), 0);
        chk("abort_sda_ena", 32'(sda_ena), 0);
        chk("abort_no_write", 32'(wr_cnt - wb), 0);
        wclk(2 * Q);

        // Reset while driving ADDR_ACK
        d = 8'h94;
        i2c_start();
        for (int i = 7; i >= 0; i--)
            bit_cycle(d[i], s);
        wclk(Q);
        chk("rstmid_in_ack", 32'(state), 4);
        chk("rstmid_driving", 32'(sda_ena), 1);
        chk("rstmid_busy", 32'(busy), 1);
        rst = 1'b1;
        wclk(1);
        chk("rstmid_state", 32'(state), 0);
        chk("rstmid_sda_ena", 32'(sda_ena), 0);
        chk("rstmid_reg_addr", 32'(reg_addr), 0);
        chk("rstmid_busy_off", 32'(busy), 0);
        rst = 1'b0;
        wclk(2);
        i2c_stop();
        chk("rstmid_stop_ignored", 32'(state), 0);

        // ena dropped while driving a read bit
        i2c_start();
        send_byte(8'h94, ack);
        send_byte(8'h20, ack);
        i2c_start();
        send_byte(8'h95, ack);
        wclk(Q);
        chk("ena_in_read", 32'(state), 9);
        chk("ena_driving", 32'(sda_ena), 1);
        ena = 1'b0;
        wclk(1);
        chk("ena_release", 32'(sda_ena), 0);
        chk("ena_idle", 32'(state), 0);
        chk("ena_reg_addr", 32'(reg_addr), 32'h20);
        ena = 1'b1;
        i2c_stop();
        chk("ena_end_idle", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
